// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: ExcCode values, the
// exception vector, FSM state encoding and the per-stage record layout.
package exc_ctrl_pkg;

    localparam int PC_W   = 32;
    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] EXC_INT  = 5'd0;
    localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;
    localparam logic [CODE_W-1:0] EXC_SYS  = 5'd8;
    localparam logic [CODE_W-1:0] EXC_BP   = 5'd9;
    localparam logic [CODE_W-1:0] EXC_RI   = 5'd10;
    localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;

    localparam logic [PC_W-1:0] EXC_VECTOR = 32'hBFC00380;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } exc_state_t;

    typedef struct packed {
        logic              valid;
        logic              exc;
        logic [CODE_W-1:0] code;
        logic [PC_W-1:0]   pc;
        logic              bd;
        logic [PC_W-1:0]   badvaddr;
        logic              eret;
    } exc_rec_t;

    // EPC points at the branch when the faulting instruction sits in a delay slot
    function automatic logic [PC_W-1:0] epc_of(input exc_rec_t r);
        return r.bd ? (r.pc - 32'd4) : r.pc;
    endfunction

endpackage

// File: rtl/exc_stage_rec.sv
// One pipeline-stage exception record. Holds on stall, clears on flush.
// qm is the registered record with this stage's own fault flags merged in;
// an already-recorded exception is never overwritten (oldest fault wins).
module exc_stage_rec
    import exc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              flush,
    input  exc_rec_t          d,
    input  logic              flg_exc,
    input  logic [CODE_W-1:0] flg_code,
    input  logic              flg_badv_en,
    input  logic [PC_W-1:0]   flg_badv,
    input  logic              flg_eret,
    output exc_rec_t          qm
);

    logic              vld_q;
    logic              exc_q;
    logic              eret_q;
    logic [CODE_W-1:0] code_q;
    logic [PC_W-1:0]   pc_q;
    logic              bd_q;
    logic [PC_W-1:0]   badv_q;

    // Control bits: reset and flush clear, stall holds
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            exc_q  <= 1'b0;
            eret_q <= 1'b0;
        end else if (flush) begin
            vld_q  <= 1'b0;
            exc_q  <= 1'b0;
            eret_q <= 1'b0;
        end else if (!stall) begin
            vld_q  <= d.valid;
            exc_q  <= d.exc;
            eret_q <= d.eret;
        end
    end

    // Payload bits: only meaningful while vld_q is set, so no reset
    always_ff @(posedge clk) begin
        if (!stall) begin
            code_q <= d.code;
            pc_q   <= d.pc;
            bd_q   <= d.bd;
            badv_q <= d.badvaddr;
        end
    end

    // Merge this stage's flags unless an older fault is already recorded
    always_comb begin
        qm          = '0;
        qm.valid    = vld_q;
        qm.exc      = exc_q;
        qm.code     = code_q;
        qm.pc       = pc_q;
        qm.bd       = bd_q;
        qm.badvaddr = badv_q;
        qm.eret     = eret_q;
        if (vld_q && !exc_q && flg_exc) begin
            qm.exc  = 1'b1;
            qm.code = flg_code;
            if (flg_badv_en) begin
                qm.badvaddr = flg_badv;
            end
        end
        if (vld_q && flg_eret) begin
            qm.eret = 1'b1;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: tracks faults through ID/EX/MEM, commits the oldest
// one (or an eret) from MEM, then spends one FLUSH cycle clearing the pipe.
// Optional macro EXC_CTRL_INT_EN enables the external interrupt path; when
// undefined the interupt input is ignored and code Int is never produced.
// The eret commit pulse is the port ret (return is a reserved word).
module exc_ctrl
    import exc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              if_bd,
    input  logic              id_ri,
    input  logic              id_sys,
    input  logic              id_bp,
    input  logic              id_eret,
    input  logic              ex_ov,
    input  logic              mem_adel,
    input  logic              mem_ades,
    input  logic [PC_W-1:0]   mem_badvaddr,
    input  logic              interupt,
    input  logic              CP0_STATUS_EXL,
    input  logic [PC_W-1:0]   return_addr,
    output logic              execption,
    output logic              ret,
    output logic [CODE_W-1:0] CP0_CAUSE_ExcCode,
    output logic [PC_W-1:0]   CP0_EPC,
    output logic              CP0_STATUS_BD,
    output logic [PC_W-1:0]   CP0_BadVaddr,
    output logic              mem_kill,
    output logic              flush,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc
);

    exc_state_t        state;
    exc_rec_t          d_p0;
    exc_rec_t          rec_p0;
    exc_rec_t          rec_p1;
    exc_rec_t          rec_p2;
    logic              id_exc;
    logic [CODE_W-1:0] id_code;
    logic              mem_exc;
    logic [CODE_W-1:0] mem_code;
    logic              int_take;
    logic              is_exc;
    logic              commit;
    logic              clr;

    // Fetch-side record and per-stage flag priority encoding
    always_comb begin
        d_p0          = '0;
        d_p0.valid    = if_valid;
        d_p0.exc      = if_valid && (if_pc[1:0] != 2'b00);
        d_p0.code     = EXC_ADEL;
        d_p0.pc       = if_pc;
        d_p0.bd       = if_bd;
        d_p0.badvaddr = if_pc;
        id_exc        = id_ri | id_sys | id_bp;
        id_code       = id_ri ? EXC_RI : (id_sys ? EXC_SYS : EXC_BP);
        mem_exc       = mem_adel | mem_ades;
        mem_code      = mem_adel ? EXC_ADEL : EXC_ADES;
    end

    assign clr = (state == ST_FLUSH);

    // ID stage
    exc_stage_rec u_rec_p0 (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(clr), .d(d_p0),
        .flg_exc(id_exc), .flg_code(id_code), .flg_badv_en(1'b0),
        .flg_badv('0), .flg_eret(id_eret), .qm(rec_p0)
    );

    // EX stage
    exc_stage_rec u_rec_p1 (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(clr), .d(rec_p0),
        .flg_exc(ex_ov), .flg_code(EXC_OV), .flg_badv_en(1'b0),
        .flg_badv('0), .flg_eret(1'b0), .qm(rec_p1)
    );

    // MEM stage
    exc_stage_rec u_rec_p2 (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(clr), .d(rec_p1),
        .flg_exc(mem_exc), .flg_code(mem_code), .flg_badv_en(1'b1),
        .flg_badv(mem_badvaddr), .flg_eret(1'b0), .qm(rec_p2)
    );

`ifdef EXC_CTRL_INT_EN
    assign int_take = rec_p2.valid && !CP0_STATUS_EXL && interupt;
`else
    logic unused_int;
    assign unused_int = interupt ^ CP0_STATUS_EXL;
    assign int_take   = 1'b0;
`endif

    assign is_exc   = rec_p2.exc || int_take;
    assign commit   = (state == ST_RUN) && rec_p2.valid && (is_exc || rec_p2.eret) && !stall;
    assign mem_kill = commit;

    // Commit FSM with registered one-cycle pulses and payload
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= ST_RUN;
            execption         <= 1'b0;
            ret               <= 1'b0;
            CP0_CAUSE_ExcCode <= '0;
            CP0_EPC           <= '0;
            CP0_STATUS_BD     <= 1'b0;
            CP0_BadVaddr      <= '0;
            flush             <= 1'b0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
        end else begin
            execption         <= 1'b0;
            ret               <= 1'b0;
            CP0_CAUSE_ExcCode <= '0;
            CP0_EPC           <= '0;
            CP0_STATUS_BD     <= 1'b0;
            CP0_BadVaddr      <= '0;
            flush             <= 1'b0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
            case (state)
                ST_RUN: begin
                    if (commit) begin
                        state          <= ST_FLUSH;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        if (is_exc) begin
                            execption         <= 1'b1;
                            CP0_CAUSE_ExcCode <= int_take ? EXC_INT : rec_p2.code;
                            CP0_EPC           <= epc_of(rec_p2);
                            CP0_STATUS_BD     <= rec_p2.bd;
                            CP0_BadVaddr      <= rec_p2.badvaddr;
                            redirect_pc       <= EXC_VECTOR;
                        end else begin
                            ret         <= 1'b1;
                            redirect_pc <= return_addr;
                        end
                    end
                end
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

endmodule
